// File: rtl/dmu_bus_ctrl_pkg.sv
// dmu_pkg: shared types and helpers for the data-memory unit.
//   size_t / SZ_*  : access size encoding on req_size
//   state_t        : bus controller FSM states
//   be_from_size   : byte enables for a size at a byte offset
//   store_lanes    : replicate LSB-aligned store data across byte lanes
//   load_extend    : pick the addressed lane from a word and sign/zero extend
//   misaligned     : illegal size or address not aligned to the access size
package dmu_pkg;

    typedef logic [1:0] size_t;

    localparam size_t SZ_B = 2'd0;
    localparam size_t SZ_H = 2'd1;
    localparam size_t SZ_W = 2'd2;
    localparam size_t SZ_X = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IO_WAIT = 2'd1,
        ST_RESP    = 2'd2
    } state_t;

    function automatic logic [3:0] be_from_size(input size_t sz, input logic [1:0] lo);
        case (sz)
            SZ_B:    return 4'b0001 << lo;
            SZ_H:    return 4'b0011 << lo;
            SZ_W:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input size_t sz, input logic [31:0] d);
        case (sz)
            SZ_B:    return {4{d[7:0]}};
            SZ_H:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] d, input size_t sz,
                                                input logic [1:0] lo, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[{lo, 3'b000} +: 8];
        h = d[{lo[1], 4'b0000} +: 16];
        case (sz)
            SZ_B:    return uns ? {24'd0, b} : {{24{b[7]}}, b};
            SZ_H:    return uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: return d;
        endcase
    endfunction

    function automatic logic misaligned(input size_t sz, input logic [1:0] lo);
        return (sz == SZ_X) || (sz == SZ_H && lo[0]) || (sz == SZ_W && lo != 2'b00);
    endfunction

endpackage

// File: rtl/dmu_bus_ctrl_if.sv
// dmu_bus_ctrl_if: CPU-side request/response bus of the data-memory unit.
//   master : CPU MEM stage (drives req_*, receives rsp_* and req_ready)
//   slave  : dmu_bus_ctrl
interface dmu_bus_ctrl_if
    import dmu_pkg::*;
#(
    parameter int ADDR_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    size_t             req_size;
    logic              req_uns;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_uns, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_uns, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmu_bus_ctrl_ram.sv
// dmu_byte_ram: 2**DM_AW x 32-bit data RAM.
//   clk      : clock
//   we[3:0]  : per-byte-lane write enables
//   re       : synchronous read enable, result on rdata after the edge
//   addr     : word index for read/write
//   wdata    : lane-positioned write data
//   rdata    : registered read data
//   dbg_addr : word index for the asynchronous debug read
//   dbg_dout : debug read data (pre-write contents during a same-edge write)
module dmu_byte_ram #(
    parameter int DM_AW = 10
) (
    input  logic             clk,
    input  logic [3:0]       we,
    input  logic             re,
    input  logic [DM_AW-1:0] addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    input  logic [DM_AW-1:0] dbg_addr,
    output logic [31:0]      dbg_dout
);
    logic [31:0] mem [2**DM_AW];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
        if (re) rdata <= mem[addr];
    end

    assign dbg_dout = mem[dbg_addr];
endmodule

// File: rtl/dmu_bus_ctrl.sv
// dmu_bus_ctrl: byte/half/word load-store engine in front of an internal data RAM
// and a memory-mapped I/O window with wait states and timeout.
//   clk, rst        : clock, synchronous active-high reset
//   bus (slave)     : single-outstanding req/rsp handshake from the CPU MEM stage
//   io_addr/io_wdata/io_be/io_we/io_rd : registered I/O access, held until io_ready
//   io_ready/io_rdata : I/O completion and read data
//   debug_addr/debug_dout : asynchronous RAM word read, independent of the FSM
module dmu_bus_ctrl
    import dmu_pkg::*;
#(
    parameter int         ADDR_W = 16,
    parameter int         DM_AW  = 10,
    parameter logic [7:0] IO_HI  = 8'hFF,
    parameter int         IO_TMO = 15
) (
    input  logic              clk,
    input  logic              rst,
    dmu_bus_ctrl_if.slave     bus,
    output logic [ADDR_W-1:0] io_addr,
    output logic [31:0]       io_wdata,
    output logic [3:0]        io_be,
    output logic              io_we,
    output logic              io_rd,
    input  logic              io_ready,
    input  logic [31:0]       io_rdata,
    input  logic [31:0]       debug_addr,
    output logic [31:0]       debug_dout
);
    localparam int CW = $clog2(IO_TMO + 1);

    state_t      state;
    logic [CW-1:0] tmo_cnt;
    logic        accept, is_io, bad;
    logic [3:0]  be, ram_we;
    logic        ram_re;
    logic [31:0] wrep, ram_q, io_q;
    logic [1:0]  s_lo;
    size_t       s_size;
    logic        s_uns, s_ram_ld;
    logic        unused_dbg;

    assign accept = (state == ST_IDLE) && bus.req_valid;
    assign is_io  = bus.req_addr[ADDR_W-1 -: 8] == IO_HI;
    assign bad    = misaligned(bus.req_size, bus.req_addr[1:0]);
    assign be     = be_from_size(bus.req_size, bus.req_addr[1:0]);
    assign wrep   = store_lanes(bus.req_size, bus.req_wdata);

    // rst wins over a coincident accept, so the RAM write is gated here too
    assign ram_we = (accept && !rst && !bad && !is_io && bus.req_we) ? be : 4'b0000;
    assign ram_re = accept && !bad && !is_io && !bus.req_we;

    assign unused_dbg = ^debug_addr[31:DM_AW];

    dmu_byte_ram #(.DM_AW(DM_AW)) u_ram (
        .clk      (clk),
        .we       (ram_we),
        .re       (ram_re),
        .addr     (bus.req_addr[DM_AW+1:2]),
        .wdata    (wrep),
        .rdata    (ram_q),
        .dbg_addr (debug_addr[DM_AW-1:0]),
        .dbg_dout (debug_dout)
    );

    // RAM loads are extended straight from the synchronous read port in RESP;
    // I/O loads were already extended into io_q; stores and errors leave io_q at 0.
    assign bus.rsp_rdata = (state != ST_RESP) ? 32'd0 :
                           s_ram_ld ? load_extend(ram_q, s_size, s_lo, s_uns) : io_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            io_addr       <= '0;
            io_wdata      <= '0;
            io_be         <= '0;
            io_we         <= 1'b0;
            io_rd         <= 1'b0;
            tmo_cnt       <= '0;
            io_q          <= '0;
            s_lo          <= '0;
            s_size        <= SZ_B;
            s_uns         <= 1'b0;
            s_ram_ld      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        bus.req_ready <= 1'b0;
                        s_lo          <= bus.req_addr[1:0];
                        s_size        <= bus.req_size;
                        s_uns         <= bus.req_uns;
                        s_ram_ld      <= 1'b0;
                        io_q          <= '0;
                        tmo_cnt       <= '0;
                        if (bad) begin
                            state         <= ST_RESP;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= 1'b1;
                        end else if (is_io) begin
                            state    <= ST_IO_WAIT;
                            io_addr  <= bus.req_addr;
                            io_wdata <= wrep;
                            io_be    <= be;
                            io_we    <= bus.req_we;
                            io_rd    <= !bus.req_we;
                        end else begin
                            state         <= ST_RESP;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= 1'b0;
                            s_ram_ld      <= !bus.req_we;
                        end
                    end
                end
                ST_IO_WAIT: begin
                    if (io_ready) begin
                        if (io_rd) io_q <= load_extend(io_rdata, s_size, s_lo, s_uns);
                        io_we         <= 1'b0;
                        io_rd         <= 1'b0;
                        io_be         <= '0;
                        state         <= ST_RESP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b0;
                    end else if (tmo_cnt == CW'(IO_TMO - 1)) begin
                        io_we         <= 1'b0;
                        io_rd         <= 1'b0;
                        io_be         <= '0;
                        state         <= ST_RESP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    bus.rsp_valid <= 1'b0;
                    bus.rsp_err   <= 1'b0;
                    bus.req_ready <= 1'b1;
                    state         <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
